// File: rtl/video_layer_mixer_if.sv
// Pixel/config/output bundle between the layer generators, the mixer and the
// TMDS path. The master drives pixels and configuration; the slave (mixer)
// drives the composited pixel and the delayed timing strobes.
interface video_layer_mixer_if #(
  parameter int NLAYERS = 4,
  parameter int COLSPC  = 10,
  parameter int LW      = $clog2(NLAYERS+1)
);
  logic                        video_enable;
  logic                        vsync;
  logic                        hsync;
  logic                        frame_start;
  logic                        line_start;
  logic [NLAYERS*3*COLSPC-1:0] layer_rgb;
  logic [NLAYERS-1:0]          cfg_enable;
  logic [2*NLAYERS-1:0]        cfg_alpha;
  logic [NLAYERS*3*COLSPC-1:0] cfg_key;
  logic [3*COLSPC-1:0]         cfg_bg;
  logic [COLSPC-1:0]           red;
  logic [COLSPC-1:0]           green;
  logic [COLSPC-1:0]           blue;
  logic                        out_vsync;
  logic                        out_hsync;
  logic                        out_frame_start;
  logic                        out_line_start;
  logic                        out_enable;
  logic [LW-1:0]               out_layer;

  modport master (
    output video_enable, vsync, hsync, frame_start, line_start, layer_rgb,
           cfg_enable, cfg_alpha, cfg_key, cfg_bg,
    input  red, green, blue, out_vsync, out_hsync, out_frame_start,
           out_line_start, out_enable, out_layer
  );

  modport slave (
    input  video_enable, vsync, hsync, frame_start, line_start, layer_rgb,
           cfg_enable, cfg_alpha, cfg_key, cfg_bg,
    output red, green, blue, out_vsync, out_hsync, out_frame_start,
           out_line_start, out_enable, out_layer
  );
endinterface

// File: rtl/video_layer_mixer.sv
// N-layer priority compositor with 2-bit alpha blend of the top visible layer
// over the next visible one. Fixed 3-stage pipeline, no stalls. Per-layer
// config is shadowed and only swapped in on frame_start so a frame never tears.
module video_layer_mixer #(
  parameter int NLAYERS = 4,
  parameter int COLSPC  = 10,
  parameter int LW      = $clog2(NLAYERS+1)
) (
  input  logic               video_clk_pix,
  input  logic               video_rst,
  video_layer_mixer_if.slave bus
);
  localparam int            CW     = 3*COLSPC;
  localparam int            WW     = COLSPC+3;
  localparam logic [LW-1:0] BG_IDX = LW'(NLAYERS);

  // strobe bundles are {video_enable, vsync, hsync, frame_start, line_start}
  logic [NLAYERS-1:0][CW-1:0] r_rgb1;
  logic [4:0]                 r_sd1, r_sd2, r_sd3;

  logic [NLAYERS-1:0]         r_en;
  logic [NLAYERS-1:0][1:0]    r_alpha;
  logic [NLAYERS-1:0][CW-1:0] r_key;
  logic [CW-1:0]              r_bg;

  logic [CW-1:0]              r_t2, r_b2;
  logic [2:0]                 r_q2;
  logic [LW-1:0]              r_idx2;

  logic [CW-1:0]              r_rgb3;
  logic [LW-1:0]              r_idx3;

  logic [NLAYERS-1:0]         w_vis;
  logic [LW-1:0]              w_t_idx;
  logic [CW-1:0]              w_t_rgb, w_b_rgb;
  logic [2:0]                 w_q;

  // q in 1..4 weights the top colour, (4-q) the colour underneath; floor /4
  function automatic logic [COLSPC-1:0] blend(input logic [COLSPC-1:0] t,
                                              input logic [COLSPC-1:0] b,
                                              input logic [2:0]        q);
    logic [WW-1:0] s;
    s = WW'(t) * WW'(q) + WW'(b) * WW'(3'd4 - q);
    return COLSPC'(s >> 2);
  endfunction

  // S1: capture pixel and strobes
  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      r_rgb1 <= '0;
      r_sd1  <= '0;
    end else begin
      r_rgb1 <= bus.layer_rgb;
      r_sd1  <= {bus.video_enable, bus.vsync, bus.hsync, bus.frame_start, bus.line_start};
    end
  end

  // active config: swapped in on the same edge that captures the frame_start pixel
  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      r_en    <= '1;
      r_alpha <= '1;
      r_key   <= '0;
      r_bg    <= '0;
    end else if (bus.frame_start) begin
      r_en    <= bus.cfg_enable;
      r_alpha <= bus.cfg_alpha;
      r_key   <= bus.cfg_key;
      r_bg    <= bus.cfg_bg;
    end
  end

  // visibility and priority pick of top (lowest index) and the one below it
  always_comb begin
    w_vis   = '0;
    w_t_idx = BG_IDX;
    w_t_rgb = r_bg;
    w_b_rgb = r_bg;
    w_q     = 3'd4;
    for (int k = 0; k < NLAYERS; k++)
      w_vis[k] = r_en[k] && (r_rgb1[k] != r_key[k]);
    for (int k = NLAYERS-1; k >= 0; k--)
      if (w_vis[k]) begin
        w_t_idx = LW'(k);
        w_t_rgb = r_rgb1[k];
        w_q     = {1'b0, r_alpha[k]} + 3'd1;
      end
    // descending scan leaves the lowest visible index above the top layer
    for (int k = NLAYERS-1; k >= 0; k--)
      if (w_vis[k] && (k > int'(w_t_idx)))
        w_b_rgb = r_rgb1[k];
    // blanked pixels are black and report the background index
    if (!r_sd1[4]) begin
      w_t_rgb = '0;
      w_b_rgb = '0;
      w_q     = 3'd4;
      w_t_idx = BG_IDX;
    end
  end

  // S2: register selected colours, weight and index
  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      r_t2   <= '0;
      r_b2   <= '0;
      r_q2   <= '0;
      r_idx2 <= '0;
      r_sd2  <= '0;
    end else begin
      r_t2   <= w_t_rgb;
      r_b2   <= w_b_rgb;
      r_q2   <= w_q;
      r_idx2 <= w_t_idx;
      r_sd2  <= r_sd1;
    end
  end

  // S3: blend per channel and register outputs
  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      r_rgb3 <= '0;
      r_idx3 <= '0;
      r_sd3  <= '0;
    end else begin
      r_rgb3 <= {blend(r_t2[CW-1:2*COLSPC],     r_b2[CW-1:2*COLSPC],     r_q2),
                 blend(r_t2[2*COLSPC-1:COLSPC], r_b2[2*COLSPC-1:COLSPC], r_q2),
                 blend(r_t2[COLSPC-1:0],        r_b2[COLSPC-1:0],        r_q2)};
      r_idx3 <= r_idx2;
      r_sd3  <= r_sd2;
    end
  end

  assign bus.red             = r_rgb3[CW-1:2*COLSPC];
  assign bus.green           = r_rgb3[2*COLSPC-1:COLSPC];
  assign bus.blue            = r_rgb3[COLSPC-1:0];
  assign bus.out_layer       = r_idx3;
  assign bus.out_enable      = r_sd3[4];
  assign bus.out_vsync       = r_sd3[3];
  assign bus.out_hsync       = r_sd3[2];
  assign bus.out_frame_start = r_sd3[1];
  assign bus.out_line_start  = r_sd3[0];
endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed + random bench for video_layer_mixer against a list-based
// reference compositor that predicts each output cycle.
module tb_video_layer_mixer;
  localparam int NL = 4;
  localparam int C  = 10;
  localparam int LW = $clog2(NL+1);
  localparam int CW = 3*C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_layer_mixer_if #(.NLAYERS(NL), .COLSPC(C)) bus();
  video_layer_mixer #(.NLAYERS(NL), .COLSPC(C)) dut (
    .video_clk_pix (clk),
    .video_rst     (rst),
    .bus           (bus)
  );

  typedef struct {
    logic [CW-1:0] rgb;
    logic [4:0]    strb;
    int            layer;
    bit            chk_layer;
  } rec_t;

  rec_t          pipe[3];
  bit            m_en[NL];
  int            m_alpha[NL];
  logic [CW-1:0] m_key[NL];
  logic [CW-1:0] m_bg;
  int            n_chk = 0;
  int            n_err = 0;
  logic [CW-1:0] pal[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // composite one pixel from the rules: list the visible layers, top is the
  // first, the one below is the second (or bg), weighted average with floor
  function automatic rec_t model_pixel();
    rec_t r;
    int vis[$];
    int q;
    logic [CW-1:0] tc, bc, px;
    r.strb = {bus.video_enable, bus.vsync, bus.hsync, bus.frame_start, bus.line_start};
    r.chk_layer = 1'b1;
    r.rgb = '0;
    r.layer = NL;
    if (!bus.video_enable) return r;
    for (int k = 0; k < NL; k++) begin
      px = bus.layer_rgb[k*CW +: CW];
      if (m_en[k] && px != m_key[k]) vis.push_back(k);
    end
    if (vis.size() == 0) begin
      r.rgb = m_bg;
      return r;
    end
    tc = bus.layer_rgb[vis[0]*CW +: CW];
    bc = (vis.size() > 1) ? bus.layer_rgb[vis[1]*CW +: CW] : m_bg;
    q  = m_alpha[vis[0]] + 1;
    for (int ch = 0; ch < 3; ch++)
      r.rgb[ch*C +: C] = C'((int'(tc[ch*C +: C]) * q + int'(bc[ch*C +: C]) * (4 - q)) / 4);
    r.layer = vis[0];
    return r;
  endfunction

  task automatic model_edge();
    rec_t z;
    if (rst) begin
      for (int k = 0; k < NL; k++) begin
        m_en[k] = 1'b1; m_alpha[k] = 3; m_key[k] = '0;
      end
      m_bg = '0;
      z.rgb = '0; z.strb = '0; z.layer = 0; z.chk_layer = 1'b1;
      pipe[2] = z;
      pipe[1] = z;
      z.chk_layer = 1'b0;   // flushed bubble: black, strobes low, index unspecified
      pipe[0] = z;
    end else begin
      if (bus.frame_start) begin
        for (int k = 0; k < NL; k++) begin
          m_en[k]    = bus.cfg_enable[k];
          m_alpha[k] = int'(bus.cfg_alpha[2*k +: 2]);
          m_key[k]   = bus.cfg_key[k*CW +: CW];
        end
        m_bg = bus.cfg_bg;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = model_pixel();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(pipe[2].rgb));
    chk("strobes", 32'({bus.out_enable, bus.out_vsync, bus.out_hsync,
                        bus.out_frame_start, bus.out_line_start}), 32'(pipe[2].strb));
    if (pipe[2].chk_layer) chk("layer", 32'(bus.out_layer), 32'(pipe[2].layer));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_layer(input int k, input logic [CW-1:0] v);
    bus.layer_rgb[k*CW +: CW] = v;
  endtask

  task automatic cfg_default();
    bus.cfg_enable = '1; bus.cfg_alpha = '1; bus.cfg_key = '0; bus.cfg_bg = '0;
  endtask

  // latch current cfg_* with one frame_start pixel, then two plain pixels
  task automatic frame_pulse();
    bus.frame_start = 1'b1; step();
    bus.frame_start = 1'b0; steps(2);
  endtask

  initial begin
    bus.video_enable = 1'b1; bus.vsync = 1'b0; bus.hsync = 1'b0;
    bus.frame_start = 1'b0; bus.line_start = 1'b0; bus.layer_rgb = '0;
    cfg_default();

    // reset state
    rst = 1'b1; steps(2);
    chk("rst_layer", 32'(bus.out_layer), 32'd0);
    rst = 1'b0;

    // reset defaults: first non-black layer wins
    set_layer(1, {10'h3FF, 20'h0}); steps(3);
    chk("def_red", 32'(bus.red), 32'h3FF);
    chk("def_layer", 32'(bus.out_layer), 32'd1);
    bus.layer_rgb = '0; steps(3);
    chk("def_bg_layer", 32'(bus.out_layer), 32'd4);

    // priority, and exact 3-cycle reaction to a change
    set_layer(0, {10'h100, 20'h0}); set_layer(2, {10'h0, 10'h200, 10'h0}); steps(3);
    chk("prio_l0", 32'(bus.out_layer), 32'd0);
    set_layer(0, '0); steps(2);
    chk("prio_hold", 32'(bus.out_layer), 32'd0);
    step();
    chk("prio_l2", 32'(bus.out_layer), 32'd2);
    chk("prio_green", 32'(bus.green), 32'h200);

    // colour key, then layer disable
    bus.cfg_key[0 +: CW] = {10'h100, 20'h0}; set_layer(0, {10'h100, 20'h0});
    frame_pulse();
    chk("key_layer", 32'(bus.out_layer), 32'd2);
    bus.cfg_enable = 4'b1011; frame_pulse();
    chk("en_bg_layer", 32'(bus.out_layer), 32'd4);

    // blend: 50%, 25%, floor
    cfg_default(); bus.layer_rgb = '0;
    set_layer(0, {10'd400, 20'h0}); set_layer(1, {10'd200, 20'h0});
    bus.cfg_alpha[1:0] = 2'd1; frame_pulse();
    chk("blend50", 32'(bus.red), 32'd300);
    bus.cfg_alpha[1:0] = 2'd0; frame_pulse();
    chk("blend25", 32'(bus.red), 32'd250);
    bus.cfg_alpha[1:0] = 2'd1; set_layer(1, {10'd201, 20'h0}); frame_pulse();
    chk("blend_floor", 32'(bus.red), 32'd300);

    // double-buffered bg: no effect until the frame_start pixel
    cfg_default(); bus.layer_rgb = '0; frame_pulse();
    bus.cfg_bg = '1; steps(6);
    chk("bg_hold", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    bus.frame_start = 1'b1; step();
    bus.frame_start = 1'b0; bus.cfg_bg = '0; step();
    chk("bg_pre", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    step();
    chk("bg_latch", 32'({bus.red, bus.green, bus.blue}), 32'h3FFF_FFFF);

    // blanking forces black
    set_layer(0, {10'h155, 10'h2AA, 10'h0FF}); bus.video_enable = 1'b0; steps(3);
    chk("blank_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    chk("blank_layer", 32'(bus.out_layer), 32'd4);
    bus.video_enable = 1'b1;

    // random traffic with a mid-line reset
    for (int i = 0; i < 4; i++) pal[i] = CW'({$urandom, $urandom});
    pal[0] = '0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NL; k++)
        set_layer(k, ($urandom_range(0, 2) != 0) ? pal[$urandom_range(0, 3)] : CW'({$urandom, $urandom}));
      bus.video_enable = ($urandom_range(0, 7) != 0);
      bus.vsync       = 1'($urandom);
      bus.hsync       = 1'($urandom);
      bus.line_start  = 1'($urandom);
      bus.frame_start = ($urandom_range(0, 7) == 0);
      bus.cfg_enable  = NL'($urandom);
      bus.cfg_alpha   = (2*NL)'($urandom);
      for (int k = 0; k < NL; k++) bus.cfg_key[k*CW +: CW] = pal[$urandom_range(0, 3)];
      bus.cfg_bg      = CW'({$urandom, $urandom});
      rst = (i == 200);
      step();
    end
    rst = 1'b0;
    steps(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
